// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first.
// A single full-subtractor cell is shared across WIDTH cycles. A borrow flop
// carries the borrow between bit positions. Results are held in dedicated
// registers until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  // Only the first WIDTH-1 difference bits need storage. The last bit goes
  // straight into diff_q on the final shift.
  logic [WIDTH-2:0] rd_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  // Full-subtractor cell outputs for the current bit position.
  logic             x;
  logic             y;
  logic             d_d;
  logic             br_d;
  logic [WIDTH-1:0] rd_shift_d;

  // Full-subtractor cell on the current LSBs, plus the shifted working result.
  // NOTE: always_comb gives every output a value on every path. That keeps
  // this block free of inferred latches.
  always_comb begin
    x          = ra_q[0];
    y          = rb_q[0];
    d_d        = x ^ y ^ br_q;
    br_d       = (~x & y) | (~(x ^ y) & br_q);
    rd_shift_d = {d_d, rd_q};
  end

  // Control FSM and datapath registers. The outputs are registered alongside
  // the state.
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the clock edge, whatever order the block is
  // written in.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, the working datapath included, is cleared by
    // reset. A reset during an operation leaves no partial result behind.
    if (!rst_n) begin
      state_q      <= IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      rd_q         <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= SHIFT;
            ra_q    <= a;
            rb_q    <= b;
            br_q    <= borrow_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        SHIFT: begin
          // start is deliberately ignored here. The operands are already
          // captured.
          ra_q  <= {1'b0, ra_q[WIDTH-1:1]};
          rb_q  <= {1'b0, rb_q[WIDTH-1:1]};
          rd_q  <= rd_shift_d[WIDTH-1:1];
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            diff_q       <= rd_shift_d;
            borrow_out_q <= br_d;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Back-to-back operation: capture the new operands immediately.
            state_q <= SHIFT;
            ra_q    <= a;
            rb_q    <= b;
            br_q    <= borrow_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8 and WIDTH = 13.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        borrow_in;
  logic        busy;
  logic        done;
  logic [7:0]  diff;
  logic        borrow_out;

  logic        start13;
  logic [12:0] a13;
  logic [12:0] b13;
  logic        bin13;
  logic        busy13;
  logic        done13;
  logic [12:0] diff13;
  logic        bo13;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .borrow_in(bin13), .busy(busy13), .done(done13), .diff(diff13),
    .borrow_out(bo13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start one 8-bit operation and wait, with a bound, for done. The task
  // returns on the negedge of the done cycle. latency is counted in cycles
  // from the start edge.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        output logic [7:0] odiff, output logic obo,
                        output int busy_cycles, output int latency, output bit timed_out);
    @(negedge clk);
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; latency = 0; timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        timed_out = 1'b0;
        latency   = i + 1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    odiff = diff;
    obo   = borrow_out;
  endtask

  task automatic run_op13(input logic [12:0] ia, input logic [12:0] ib, input logic ibin,
                          output logic [12:0] odiff, output logic obo,
                          output int busy_cycles, output bit timed_out);
    @(negedge clk);
    a13 = ia; b13 = ib; bin13 = ibin; start13 = 1'b1;
    @(negedge clk);
    start13 = 1'b0;
    busy_cycles = 0; timed_out = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done13) begin
        timed_out = 1'b0;
        break;
      end
      if (busy13) busy_cycles++;
      @(negedge clk);
    end
    odiff = diff13;
    obo   = bo13;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [7:0]  got_d;
    logic        got_bo;
    int          bc;
    int          lat;
    bit          to;
    bit          saw_done;
    logic [8:0]  ref9;
    logic [13:0] ref14;
    logic [12:0] got_d13;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rbin;
    logic [12:0] ra13;
    logic [12:0] rb13;

    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    vecs[1] = '{8'd37,  8'd100, 1'b0, 8'd193, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
    vecs[4] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1};
    vecs[5] = '{8'd200, 8'd55,  1'b1, 8'd144, 1'b0};
    vecs[6] = '{8'd128, 8'd127, 1'b1, 8'd0,   1'b0};
    vecs[7] = '{8'd5,   8'd5,   1'b1, 8'd255, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset diff", 64'(diff), 64'd0);
    check("reset borrow_out", 64'(borrow_out), 64'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, got_d, got_bo, bc, lat, to);
      check($sformatf("vec%0d timeout", i), 64'(to), 64'd0);
      check($sformatf("vec%0d diff", i), 64'(got_d), 64'(vecs[i].exp_diff));
      check($sformatf("vec%0d borrow_out", i), 64'(got_bo), 64'(vecs[i].exp_bo));
      check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'd8);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
    end

    // A start pulsed during SHIFT with new operands is ignored.
    @(negedge clk);
    a = 8'd100; b = 8'd37; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd2; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored start busy", 64'(busy), 64'd1);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    check("ignored start timeout", 64'(to), 64'd0);
    check("ignored start diff", 64'(diff), 64'd63);
    check("ignored start borrow_out", 64'(borrow_out), 64'd0);
    @(negedge clk);
    check("ignored start no restart", 64'(busy), 64'd0);

    // Hold start through DONE: 50-20 = 30, then back-to-back 10-20 = 246.
    @(negedge clk);
    a = 8'd50; b = 8'd20; borrow_in = 1'b0; start = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
    check("held start timeout 1", 64'(to), 64'd0);
    check("held start diff 1", 64'(diff), 64'd30);
    a = 8'd10; b = 8'd20; borrow_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("back-to-back busy", 64'(busy), 64'd1);
    check("back-to-back done low", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("diff held in second op", 64'(diff), 64'd30);
    check("borrow_out held in second op", 64'(borrow_out), 64'd0);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    check("held start timeout 2", 64'(to), 64'd0);
    check("held start diff 2", 64'(diff), 64'd246);
    check("held start borrow_out 2", 64'(borrow_out), 64'd1);

    // Reset in the fourth SHIFT cycle. The outputs clear at once and no done
    // follows.
    @(negedge clk);
    a = 8'd200; b = 8'd1; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset diff", 64'(diff), 64'd0);
    check("mid reset borrow_out", 64'(borrow_out), 64'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abandoned op silent", 64'(saw_done), 64'd0);
    run_op(8'd10, 8'd3, 1'b0, got_d, got_bo, bc, lat, to);
    check("post reset timeout", 64'(to), 64'd0);
    check("post reset diff", 64'(got_d), 64'd7);
    check("post reset borrow_out", 64'(got_bo), 64'd0);

    // Random regression against a wide-subtract model at WIDTH = 8
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
      run_op(ra, rb, rbin, got_d, got_bo, bc, lat, to);
      check($sformatf("rand8 %0d-%0d-%0d result", ra, rb, rbin),
            {55'd0, got_bo, got_d, 1'b0}, {55'd0, ref9[8], ref9[7:0], to});
      check("rand8 busy cycles", 64'(bc), 64'd8);
    end

    // Random regression against a wide-subtract model at WIDTH = 13
    for (int n = 0; n < 300; n++) begin
      ra13 = 13'($urandom); rb13 = 13'($urandom); rbin = 1'($urandom);
      if (n == 0) begin ra13 = '0; rb13 = '1; rbin = 1'b1; end
      ref14 = {1'b0, ra13} - {1'b0, rb13} - 14'(rbin);
      run_op13(ra13, rb13, rbin, got_d13, got_bo, bc, to);
      check($sformatf("rand13 %0d-%0d-%0d result", ra13, rb13, rbin),
            {49'd0, got_bo, got_d13, 1'b0}, {49'd0, ref14[13], ref14[12:0], to});
      check("rand13 busy cycles", 64'(bc), 64'd13);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
